// File: rtl/csa32_accumulator_if.sv
// Accumulator stream bundle: word input and packet-result output handshakes.
interface csa32_accumulator_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_count
  );
endinterface

// File: rtl/csa32_accumulator.sv
// Packet accumulator around a 32-bit carry-skip adder; result valid the cycle after the last word.
// Result held until out_ready; no word accepted while a result is pending.
module cskipa32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);
  logic [31:0] p;
  logic [31:0] g;
  logic        carry;
  logic        blk_cin;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // 8 ripple blocks of 4 bits; a fully-propagating block forwards its carry-in directly.
  always_comb begin
    sum_o   = '0;
    carry   = cin_i;
    blk_cin = cin_i;
    for (int blk = 0; blk < 8; blk++) begin
      blk_cin = carry;
      for (int i = 0; i < 4; i++) begin
        sum_o[blk*4+i] = p[blk*4+i] ^ carry;
        carry          = g[blk*4+i] | (p[blk*4+i] & carry);
      end
      if (&p[blk*4 +: 4]) carry = blk_cin;
    end
    cout_o = carry;
  end
endmodule

module csa32_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  csa32_accumulator_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_q;
  logic [31:0]      acc_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic [31:0]      acc_d;
  logic             ovf_d;
  logic [CNT_W-1:0] cnt_d;
  logic             cout;
  logic             accept;

  cskipa32 u_adder (
    .a_i    (acc_q),
    .b_i    (bus.in_data),
    .cin_i  (1'b0),
    .sum_o  (acc_d),
    .cout_o (cout)
  );

  assign accept = bus.in_valid & bus.in_ready;
  assign ovf_d  = ovf_q | cout;
  assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            if (bus.in_last) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              state_q <= ACC;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          acc_q       <= '0;
          ovf_q       <= 1'b0;
          cnt_q       <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Reset must block acceptance immediately, not just at the next edge.
  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_count = cnt_q;
endmodule
